// File: rtl/spi_master_tx_serializer_if.sv
// ============================================================================
// spi_master_tx_serializer_if : TX FIFO handshake, clock-gen control, SDO lines
// Rev 1.0
// ============================================================================
`default_nettype none

interface spi_master_tx_serializer_if;
  logic        en;
  logic        en_quad_in;
  logic [15:0] counter_in;
  logic        tx_edge;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready;
  logic        clk_en_o;
  logic        tx_done;
  logic        sdo0;
  logic        sdo1;
  logic        sdo2;
  logic        sdo3;

  // Controller / FIFO / clock-generator side
  modport master (
    output en, en_quad_in, counter_in, tx_edge, data, data_valid,
    input  data_ready, clk_en_o, tx_done, sdo0, sdo1, sdo2, sdo3
  );

  // Serializer side
  modport slave (
    input  en, en_quad_in, counter_in, tx_edge, data, data_valid,
    output data_ready, clk_en_o, tx_done, sdo0, sdo1, sdo2, sdo3
  );
endinterface

`default_nettype wire

// File: rtl/spi_master_tx_serializer.sv
// ============================================================================
// spi_master_tx_serializer : SPI master TX shifter, standard or quad, MSB first
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_master_tx_serializer (
  input  wire                           clk,
  input  wire                           rst,
  spi_master_tx_serializer_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRANSMIT  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] sreg, sreg_next;
  logic [15:0] counter, counter_next;
  logic [15:0] target, target_next;
  logic        quad, quad_next;
  logic        done_next;
  logic        clk_en_q;
  logic        done_q;

  logic [15:0] target_in;
  logic        last_unit;
  logic        word_boundary;

  // Quad mode counts nibbles; a length that is not a multiple of 4 truncates.
  assign target_in     = bus.en_quad_in ? (bus.counter_in >> 2) : bus.counter_in;
  assign last_unit     = (counter == (target - 16'd1));
  assign word_boundary = quad ? (counter[2:0] == 3'd7) : (counter[4:0] == 5'd31);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= 32'd0;
      counter  <= 16'd0;
      target   <= 16'd0;
      quad     <= 1'b0;
      clk_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_next;
      sreg     <= sreg_next;
      counter  <= counter_next;
      target   <= target_next;
      quad     <= quad_next;
      // Drops the cycle after the final/starving tx_edge, while SCLK is low.
      clk_en_q <= (state_next == TRANSMIT);
      done_q   <= done_next;
    end
  end

  always_comb begin
    state_next     = state;
    sreg_next      = sreg;
    counter_next   = counter;
    target_next    = target;
    quad_next      = quad;
    done_next      = 1'b0;
    bus.data_ready = 1'b0;

    case (state)
      IDLE: begin
        if (bus.en) begin
          if (target_in == 16'd0) begin
            done_next = 1'b1;
          end else if (bus.data_valid) begin
            bus.data_ready = 1'b1;
            sreg_next      = bus.data;
            counter_next   = 16'd0;
            target_next    = target_in;
            quad_next      = bus.en_quad_in;
            state_next     = TRANSMIT;
          end
        end
      end

      TRANSMIT: begin
        if (bus.tx_edge) begin
          if (last_unit) begin
            done_next    = 1'b1;
            counter_next = 16'd0;
            state_next   = IDLE;
          end else if (word_boundary) begin
            counter_next = counter + 16'd1;
            if (bus.data_valid) begin
              bus.data_ready = 1'b1;
              sreg_next      = bus.data;
            end else begin
              state_next = WAIT_DATA;
            end
          end else begin
            counter_next = counter + 16'd1;
            sreg_next    = quad ? {sreg[27:0], 4'h0} : {sreg[30:0], 1'b0};
          end
        end
      end

      WAIT_DATA: begin
        if (bus.data_valid) begin
          bus.data_ready = 1'b1;
          sreg_next      = bus.data;
          state_next     = TRANSMIT;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.clk_en_o = clk_en_q;
  assign bus.tx_done  = done_q;

  always_comb begin
    if (quad) begin
      {bus.sdo3, bus.sdo2, bus.sdo1, bus.sdo0} = sreg[31:28];
    end else begin
      {bus.sdo3, bus.sdo2, bus.sdo1, bus.sdo0} = {3'b000, sreg[31]};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_tx_serializer.sv
// ============================================================================
// tb_spi_master_tx_serializer : directed bench for the SPI TX serializer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_master_tx_serializer;

  logic clk;
  logic rst;

  spi_master_tx_serializer_if bus ();

  spi_master_tx_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed;
  int total;
  int dr_cnt;
  int done_cnt;
  int clken_cnt;

  always @(posedge clk) begin
    if (bus.data_ready === 1'b1) dr_cnt++;
    if (bus.tx_done === 1'b1) done_cnt++;
    if (bus.clk_en_o === 1'b1) clken_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle, then a one-cycle falling-edge strobe.
  task automatic pulse_edge();
    tick();
    bus.tx_edge = 1'b1;
    tick();
    bus.tx_edge = 1'b0;
  endtask

  task automatic start(input logic [31:0] word, input logic [15:0] len, input logic q);
    bus.data       = word;
    bus.counter_in = len;
    bus.en_quad_in = q;
    bus.data_valid = 1'b1;
    bus.en         = 1'b1;
    #1;
    chk("start_ready", bus.data_ready, 1);
    tick();
    bus.en         = 1'b0;
    bus.data_valid = 1'b0;
    bus.data       = 32'd0;
    chk("start_clk_en", bus.clk_en_o, 1);
  endtask

  logic [7:0]  exp8;
  logic [31:0] w0, w1;
  logic [15:0] nib;
  int dr0, ce0, done0;

  initial begin
    passed = 0; total = 0; dr_cnt = 0; done_cnt = 0; clken_cnt = 0;
    bus.en = 0; bus.en_quad_in = 0; bus.counter_in = 0; bus.tx_edge = 0;
    bus.data = 0; bus.data_valid = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk_en", bus.clk_en_o, 0);
    chk("rst_tx_done", bus.tx_done, 0);
    chk("rst_sdo", {bus.sdo3, bus.sdo2, bus.sdo1, bus.sdo0}, 0);
    chk("rst_ready", bus.data_ready, 0);
    rst = 1'b0;
    tick();

    // Standard 8 bits of 0xA5
    dr0 = dr_cnt;
    exp8 = 8'hA5;
    start(32'hA500_0000, 16'd8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("t1_sdo0", bus.sdo0, exp8[7-i]);
      if (i == 0) chk("t1_sdo_hi", {bus.sdo3, bus.sdo2, bus.sdo1}, 0);
      chk("t1_no_done", bus.tx_done, 0);
      pulse_edge();
    end
    chk("t1_done", bus.tx_done, 1);
    chk("t1_clk_en_off", bus.clk_en_o, 0);
    tick();
    chk("t1_done_one_cycle", bus.tx_done, 0);
    chk("t1_ready_pulses", dr_cnt - dr0, 1);

    // Standard 40 bits with starved second word
    dr0 = dr_cnt;
    w0 = 32'hC000_0001;
    w1 = 32'hB000_0000;
    start(w0, 16'd40, 1'b0);
    for (int i = 0; i < 32; i++) begin
      chk("t2_w0_bit", bus.sdo0, w0[31-i]);
      pulse_edge();
    end
    chk("t2_wait_clk_en", bus.clk_en_o, 0);
    chk("t2_wait_no_done", bus.tx_done, 0);
    for (int i = 0; i < 10; i++) begin
      bus.tx_edge = (i == 5);
      tick();
    end
    bus.tx_edge = 1'b0;
    chk("t2_wait_clk_en_held", bus.clk_en_o, 0);
    chk("t2_wait_sdo_held", bus.sdo0, 1);
    chk("t2_wait_ready_pulses", dr_cnt - dr0, 1);
    bus.data = w1;
    bus.data_valid = 1'b1;
    #1;
    chk("t2_resume_ready", bus.data_ready, 1);
    tick();
    bus.data_valid = 1'b0;
    chk("t2_resume_clk_en", bus.clk_en_o, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t2_w1_bit", bus.sdo0, w1[31-i]);
      chk("t2_w1_no_done", bus.tx_done, 0);
      pulse_edge();
    end
    chk("t2_done", bus.tx_done, 1);
    chk("t2_ready_pulses", dr_cnt - dr0, 2);
    tick();

    // Quad 16 bits of 0x1234ABCD, controls changed mid-transfer
    dr0 = dr_cnt;
    nib = 16'h1234;
    start(32'h1234_ABCD, 16'd16, 1'b1);
    bus.en_quad_in = 1'b0;
    bus.counter_in = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      chk("t3_nibble", {bus.sdo3, bus.sdo2, bus.sdo1, bus.sdo0}, nib[15-4*i -: 4]);
      chk("t3_no_done", bus.tx_done, 0);
      pulse_edge();
    end
    chk("t3_done", bus.tx_done, 1);
    chk("t3_clk_en_off", bus.clk_en_o, 0);
    chk("t3_ready_pulses", dr_cnt - dr0, 1);
    tick();
    chk("t3_idle_after", bus.clk_en_o, 0);

    // Zero-length transfers: standard 0 and quad 3
    dr0 = dr_cnt;
    ce0 = clken_cnt;
    for (int k = 0; k < 2; k++) begin
      bus.data       = 32'hFFFF_FFFF;
      bus.data_valid = 1'b1;
      bus.en_quad_in = (k == 1);
      bus.counter_in = (k == 1) ? 16'd3 : 16'd0;
      bus.en         = 1'b1;
      #1;
      chk("t4_no_ready", bus.data_ready, 0);
      tick();
      bus.en = 1'b0;
      chk("t4_done", bus.tx_done, 1);
      chk("t4_clk_en", bus.clk_en_o, 0);
      tick();
      chk("t4_done_one_cycle", bus.tx_done, 0);
    end
    bus.data_valid = 1'b0;
    chk("t4_ready_pulses", dr_cnt - dr0, 0);
    chk("t4_clk_en_cycles", clken_cnt - ce0, 0);

    // Async reset after bit 5 of a 32-bit transfer
    start(32'hFFFF_FFFF, 16'd32, 1'b0);
    for (int i = 0; i < 5; i++) pulse_edge();
    chk("t5_pre_sdo0", bus.sdo0, 1);
    done0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("t5_rst_clk_en", bus.clk_en_o, 0);
    chk("t5_rst_sdo", {bus.sdo3, bus.sdo2, bus.sdo1, bus.sdo0}, 0);
    chk("t5_rst_done", bus.tx_done, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("t5_no_done_pulse", done_cnt - done0, 0);
    chk("t5_idle_clk_en", bus.clk_en_o, 0);

    dr0 = dr_cnt;
    exp8 = 8'h3C;
    start(32'h3C00_0000, 16'd8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("t5_sdo0", bus.sdo0, exp8[7-i]);
      pulse_edge();
    end
    chk("t5_done", bus.tx_done, 1);
    chk("t5_ready_pulses", dr_cnt - dr0, 1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
